max_pool2x2_32channel_layer4: RTL and testbench
===============================================

Name: max_pool2x2_32channel_layer4

Overview:
- Streaming 2x2 stride-2 max-pooling stage for 32 channels, placed directly downstream of the layer-4 separable convolution.
- Consumes one raster-order pixel per Valid_In (all 32 channels in parallel) and emits one pooled pixel per 2x2 window.
- A 44x44 input map becomes a 22x22 output map for the next layer.

Parameters:
DATA_WIDHT, 32, width of one channel sample, signed two's complement fixed point
IMG_WIDHT, 44, input map width in pixels; must be even and >= 2
IMG_HEIGHT, 44, input map height in pixels; must be even and >= 2
CHANNELS, 32, channel count packed in Data_In/Data_Out

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
Data_In  input  DATA_WIDHT*CHANNELS  packed pixel; channel c at bits [c*DATA_WIDHT +: DATA_WIDHT]
Valid_In  input  1  Data_In is valid this cycle; no backpressure
Data_Out  output  DATA_WIDHT*CHANNELS  pooled pixel, same packing
Valid_Out  output  1  Data_Out valid, single-cycle pulse
Frame_Done  output  1  pulses together with Valid_Out for the last pooled pixel of a frame

Behaviour:
- Reset (rst low, asynchronous): col_cnt=0, row_cnt=0, h_max register=0, Data_Out=0, Valid_Out=0, Frame_Done=0. Line buffer contents are don't-care.
- Counters advance only when Valid_In=1. Gaps of any length between valid pixels are allowed and leave state unchanged.
  - col_cnt wraps IMG_WIDHT-1 -> 0 and then increments row_cnt.
  - row_cnt wraps IMG_HEIGHT-1 -> 0, so frames are back-to-back with no idle cycles required.
- Pooling state (from col_cnt[0]/row_cnt[0]):
  - EVEN_COL: store the sample in h_max.
  - ODD_COL, EVEN_ROW: write max(h_max, Data_In) per channel into line buffer entry col_cnt>>1.
  - ODD_COL, ODD_ROW: compute max(linebuf[col_cnt>>1], h_max, Data_In) per channel and register it into Data_Out; set Valid_Out=1 on the next cycle.
- Line buffer: IMG_WIDHT/2 entries x DATA_WIDHT*CHANNELS bits. Entries are written and read at the same index in different rows, so there are no read/write collisions.
- Latency: Valid_Out asserts exactly 1 clock after the Valid_In of the bottom-right pixel of each window.
- Data_Out holds its value between pulses. Valid_Out and Frame_Done are 0 in every other cycle.
- Comparisons are signed and per channel. On ties either operand may be selected (values are equal). There is no width growth.
- Frame_Done=1 with the Valid_Out for row_cnt=IMG_HEIGHT-1, col_cnt=IMG_WIDHT-1.
- Reset mid-frame: all counters restart at 0, and the next Valid_In is treated as pixel (0,0). No stale output is produced, because the line buffer is always rewritten before it is read.
- Output rate: one output per 4 inputs; 484 outputs per 44x44 frame.

Optional Feature:
- Macro: MAX_POOL_RELU_FUSE_EN.
- Defined: each channel of the pooled result is clamped to 0 if negative before it is registered into Data_Out. This is a fused ReLU; latency is unchanged.
- Undefined: the raw signed maximum is output, and negative values pass through.

Decomposition:
- Shared package holds:
  - CHANNELS=32;
  - pooled dimensions (IMG_WIDHT/2, IMG_HEIGHT/2);
  - line-buffer depth constant;
  - the signed sample typedef of DATA_WIDHT bits.
- One sub-module, max_pool_cmp_channel: a combinational signed max of two DATA_WIDHT operands with optional ReLU clamp. It is instantiated CHANNELS times per comparison level via generate.
- Counters, line buffer and output register stay in the top.

Test Plan:
- IMG_WIDHT=4, IMG_HEIGHT=4, channel 0 input = raster index 0..15, other channels 0, Valid_In continuous -> 4 outputs with channel 0 values 5, 7, 13, 15, each 1 cycle after input index 5, 7, 13, 15; Frame_Done only with 15.
- Channel 3 window values {-8,-3,-20,-1} -> Data_Out channel 3 = -1 without the macro, 0 with MAX_POOL_RELU_FUSE_EN defined.
- Same 4x4 stream with Valid_In toggling 1/0 randomly -> identical output values and order; each Valid_Out occurs 1 cycle after the qualifying valid input.
- rst pulsed low after pixel 9 of a 4x4 frame, then a fresh full frame sent -> outputs are only 4 pulses from the fresh frame with correct maxima, and all outputs are 0 during reset.
- Full 44x44 default frame of random signed data on all 32 channels, two frames back-to-back -> exactly 484 Valid_Out per frame matching the reference model, and Frame_Done exactly twice.
- Window where all 4 samples = 0x7FFFFFFF or all = 0x80000000 -> output equals that extreme value (0 for 0x80000000 with ReLU), with no overflow.

Source files
------------

// File: rtl/max_pool2x2_32channel_layer4_pkg.sv
// -----------------------------------------------------------------------------
// max_pool2x2_32channel_layer4_pkg
// Shared constants and types for the layer-4 2x2 stride-2 max-pooling stage.
//   SAMPLE_WIDHT  : width of one signed channel sample
//   NUM_CHANNELS  : channels carried in parallel per pixel
//   IN_WIDHT/IN_HEIGHT   : default input map size (44x44)
//   OUT_WIDHT/OUT_HEIGHT : pooled map size (22x22)
//   LINEBUF_DEPTH : one entry per horizontal window in a row
//   POOL_PH_*     : pooling phase encodings, {row_cnt[0], col_cnt[0]}
// -----------------------------------------------------------------------------
package max_pool2x2_32channel_layer4_pkg;

  localparam int SAMPLE_WIDHT  = 32;
  localparam int NUM_CHANNELS  = 32;
  localparam int IN_WIDHT      = 44;
  localparam int IN_HEIGHT     = 44;
  localparam int OUT_WIDHT     = IN_WIDHT / 2;
  localparam int OUT_HEIGHT    = IN_HEIGHT / 2;
  localparam int LINEBUF_DEPTH = IN_WIDHT / 2;

  // One channel sample: signed two's complement fixed point.
  typedef logic signed [SAMPLE_WIDHT-1:0] sample_t;

  // Pooling phase, indexed by {row parity, column parity}. Both even-column
  // encodings behave identically (latch the sample into h_max).
  localparam logic [1:0] POOL_PH_EVEN_ROW_EVEN_COL = 2'b00;
  localparam logic [1:0] POOL_PH_EVEN_ROW_ODD_COL  = 2'b01;
  localparam logic [1:0] POOL_PH_ODD_ROW_EVEN_COL  = 2'b10;
  localparam logic [1:0] POOL_PH_ODD_ROW_ODD_COL   = 2'b11;

endpackage

// File: rtl/max_pool2x2_32channel_layer4_cmp_channel.sv
// -----------------------------------------------------------------------------
// max_pool_cmp_channel
// Combinational signed maximum of two samples with an optional ReLU clamp.
//   a, b : signed operands, DATA_WIDHT bits
//   y    : max(a, b); forced to 0 when RELU_EN is set and the max is negative
// No width growth: the result is always one of the operands (or zero).
// -----------------------------------------------------------------------------
module max_pool_cmp_channel
  import max_pool2x2_32channel_layer4_pkg::*;
#(
  parameter int DATA_WIDHT = SAMPLE_WIDHT,
  parameter bit RELU_EN    = 1'b0
) (
  input  logic signed [DATA_WIDHT-1:0] a,
  input  logic signed [DATA_WIDHT-1:0] b,
  output logic signed [DATA_WIDHT-1:0] y
);

  logic signed [DATA_WIDHT-1:0] m;

  // NOTE: every signal written in always_comb gets a value on every path;
  // a missing branch would infer a latch.
  always_comb begin
    m = (a >= b) ? a : b;
    y = m;
    if (RELU_EN && m[DATA_WIDHT-1]) begin
      y = '0;
    end
  end

endmodule

// File: rtl/max_pool2x2_32channel_layer4.sv
// -----------------------------------------------------------------------------
// max_pool2x2_32channel_layer4
// Streaming 2x2 stride-2 max pooling over CHANNELS signed channels in parallel.
// Input pixels arrive in raster order, one per Valid_In; one pooled pixel is
// produced per 2x2 window, one clock after the window's bottom-right pixel.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   Data_In    : packed pixel, channel c at [c*DATA_WIDHT +: DATA_WIDHT]
//   Valid_In   : Data_In valid this cycle (no backpressure, gaps allowed)
//   Data_Out   : pooled pixel, same packing; holds between pulses
//   Valid_Out  : single-cycle pulse when Data_Out is updated
//   Frame_Done : pulses with Valid_Out for the last pooled pixel of a frame
//
// Build option:
//   MAX_POOL_RELU_FUSE_EN : when defined, each pooled channel is clamped to 0
//   if negative before registering (fused ReLU, same latency).
// -----------------------------------------------------------------------------
module max_pool2x2_32channel_layer4
  import max_pool2x2_32channel_layer4_pkg::*;
#(
  parameter int DATA_WIDHT = SAMPLE_WIDHT,
  parameter int IMG_WIDHT  = IN_WIDHT,
  parameter int IMG_HEIGHT = IN_HEIGHT,
  parameter int CHANNELS   = NUM_CHANNELS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
  input  logic                           Valid_In,
  output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
  output logic                           Valid_Out,
  output logic                           Frame_Done
);

  localparam int PIX_W    = DATA_WIDHT * CHANNELS;
  localparam int LB_DEPTH = IMG_WIDHT / 2;
  localparam int COL_W    = (IMG_WIDHT  > 2) ? $clog2(IMG_WIDHT)  : 1;
  localparam int ROW_W    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_AW    = (LB_DEPTH   > 1) ? $clog2(LB_DEPTH)   : 1;

`ifdef MAX_POOL_RELU_FUSE_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [PIX_W-1:0] h_max;                     // left sample of current pair
  logic [PIX_W-1:0] line_buf [LB_DEPTH];       // horizontal maxima of even row

  // ---------------------------------------------------------------------------
  // Position decode
  // ---------------------------------------------------------------------------
  logic             col_last;
  logic             row_last;
  logic [1:0]       phase;
  logic [LB_AW-1:0] lb_idx;
  logic [PIX_W-1:0] lb_rd;

  assign col_last = (col_cnt == COL_W'(IMG_WIDHT - 1));
  assign row_last = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
  assign phase    = {row_cnt[0], col_cnt[0]};
  // Each horizontal window (column pair) owns one line-buffer entry.
  assign lb_idx   = LB_AW'(col_cnt >> 1);
  // The odd row reads the entry its even row wrote at the same index, so a
  // read never races a write to the same location.
  assign lb_rd    = line_buf[lb_idx];

  // ---------------------------------------------------------------------------
  // Per-channel comparators
  //   pair_max   : max(h_max, Data_In), the horizontal max of the current pair
  //   window_max : max(line buffer, pair_max), the full 2x2 result (+ ReLU)
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] pair_max;
  logic [PIX_W-1:0] window_max;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    max_pool_cmp_channel #(
      .DATA_WIDHT (DATA_WIDHT),
      .RELU_EN    (1'b0)
    ) u_pair_cmp (
      .a (h_max   [c*DATA_WIDHT +: DATA_WIDHT]),
      .b (Data_In [c*DATA_WIDHT +: DATA_WIDHT]),
      .y (pair_max[c*DATA_WIDHT +: DATA_WIDHT])
    );

    // The clamp belongs on the final level only: the line buffer must keep
    // raw maxima so a negative row result still competes correctly.
    max_pool_cmp_channel #(
      .DATA_WIDHT (DATA_WIDHT),
      .RELU_EN    (RELU_EN)
    ) u_window_cmp (
      .a (lb_rd     [c*DATA_WIDHT +: DATA_WIDHT]),
      .b (pair_max  [c*DATA_WIDHT +: DATA_WIDHT]),
      .y (window_max[c*DATA_WIDHT +: DATA_WIDHT])
    );
  end

  // ---------------------------------------------------------------------------
  // Counters, horizontal register and output register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      h_max      <= '0;
      Data_Out   <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      // Pulses are high only in the cycle right after a qualifying pixel.
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;

      if (Valid_In) begin
        // Raster position; frames run back-to-back with no idle cycle.
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end

        case (phase)
          POOL_PH_ODD_ROW_ODD_COL: begin
            Data_Out   <= window_max;
            Valid_Out  <= 1'b1;
            Frame_Done <= row_last && col_last;
          end
          POOL_PH_EVEN_ROW_ODD_COL: begin
            // Line buffer written in its own block below.
          end
          default: begin
            // Either even-column phase: start a new horizontal pair.
            h_max <= Data_In;
          end
        endcase
      end
    end
  end

  // NOTE: the line buffer has no reset; every entry is rewritten in an even
  // row before the following odd row reads it, so its power-up contents never
  // reach Data_Out, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (Valid_In && (phase == POOL_PH_EVEN_ROW_ODD_COL)) begin
      line_buf[lb_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_max_pool2x2_32channel_layer4.sv
// -----------------------------------------------------------------------------
// tb_max_pool2x2_32channel_layer4
// Scoreboard bench for max_pool2x2_32channel_layer4. A 4x4 instance covers the
// directed windows, gapped input, extreme values and mid-frame reset; a
// default 44x44 instance takes two back-to-back random frames.
// The reference model keeps whole input frames in arrays and takes the plain
// signed maximum of each 2x2 window when its bottom-right pixel is issued.
// -----------------------------------------------------------------------------
module tb_max_pool2x2_32channel_layer4;
  import max_pool2x2_32channel_layer4_pkg::*;

  localparam int DW = 32;
  localparam int CH = 32;
  localparam int PW = DW * CH;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int BW = 44;
  localparam int BH = 44;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] din_s, dout_s, din_b, dout_b;
  logic          vin_s, vout_s, fd_s, vin_b, vout_b, fd_b;

  always #5 clk = ~clk;

  max_pool2x2_32channel_layer4 #(
    .DATA_WIDHT (DW), .IMG_WIDHT (SW), .IMG_HEIGHT (SH), .CHANNELS (CH)
  ) dut_small (
    .clk (clk), .rst (rst),
    .Data_In (din_s), .Valid_In (vin_s),
    .Data_Out (dout_s), .Valid_Out (vout_s), .Frame_Done (fd_s)
  );

  max_pool2x2_32channel_layer4 dut_big (
    .clk (clk), .rst (rst),
    .Data_In (din_b), .Valid_In (vin_b),
    .Data_Out (dout_b), .Valid_Out (vout_b), .Frame_Done (fd_b)
  );

  typedef struct {
    logic [PW-1:0] data;
    logic          fd;
    int unsigned   cyc;
  } exp_t;

  exp_t          q_s[$];
  exp_t          q_b[$];
  logic [PW-1:0] img_s [SW*SH];
  logic [PW-1:0] img_b [BW*BH];
  int            pix_s = 0;
  int            pix_b = 0;
  int            checks = 0;
  int            errors = 0;
  int            n_vout_b = 0;
  int            n_fd_b = 0;
  int unsigned   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reports the first differing channel so each line stays short.
  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      int ch_bad = 0;
      for (int c = CH - 1; c >= 0; c--)
        if (act[c*DW +: DW] !== exp[c*DW +: DW]) ch_bad = c;
      errors++;
      $display("FAIL %s ch=%0d act=%h exp=%h", name, ch_bad,
               act[ch_bad*DW +: DW], exp[ch_bad*DW +: DW]);
    end
  endtask

  function automatic logic [PW-1:0] pool4(input logic [PW-1:0] a,
                                          input logic [PW-1:0] b,
                                          input logic [PW-1:0] c,
                                          input logic [PW-1:0] d);
    logic [PW-1:0] r;
    sample_t       s [4];
    sample_t       m;
    for (int ch = 0; ch < CH; ch++) begin
      s[0] = a[ch*DW +: DW];
      s[1] = b[ch*DW +: DW];
      s[2] = c[ch*DW +: DW];
      s[3] = d[ch*DW +: DW];
      m = s[0];
      for (int k = 1; k < 4; k++) if (s[k] > m) m = s[k];
`ifdef MAX_POOL_RELU_FUSE_EN
      if (m < 0) m = '0;
`endif
      r[ch*DW +: DW] = m;
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = $urandom;
    return r;
  endfunction

  // Drives one cycle of the small DUT; valid pixels feed the model.
  task automatic send_s(input logic [PW-1:0] d, input logic v);
    int r, c;
    @(negedge clk);
    din_s = d;
    vin_s = v;
    if (v) begin
      img_s[pix_s] = d;
      r = pix_s / SW;
      c = pix_s % SW;
      if ((r % 2 == 1) && (c % 2 == 1))
        q_s.push_back('{pool4(img_s[pix_s-SW-1], img_s[pix_s-SW],
                              img_s[pix_s-1], d),
                        (r == SH - 1) && (c == SW - 1), cyc + 1});
      pix_s = (pix_s + 1) % (SW * SH);
    end
  endtask

  task automatic send_b(input logic [PW-1:0] d, input logic v);
    int r, c;
    @(negedge clk);
    din_b = d;
    vin_b = v;
    if (v) begin
      img_b[pix_b] = d;
      r = pix_b / BW;
      c = pix_b % BW;
      if ((r % 2 == 1) && (c % 2 == 1))
        q_b.push_back('{pool4(img_b[pix_b-BW-1], img_b[pix_b-BW],
                              img_b[pix_b-1], d),
                        (r == BH - 1) && (c == BW - 1), cyc + 1});
      pix_b = (pix_b + 1) % (BW * BH);
    end
  endtask

  task automatic drain_s();
    int k = 0;
    while (q_s.size() != 0 && k < 20) begin
      send_s(rand_pix(), 1'b0);
      k++;
    end
    send_s('0, 1'b0);
    check("drain_small", PW'(q_s.size()), '0);
  endtask

  task automatic drain_b();
    int k = 0;
    while (q_b.size() != 0 && k < 20) begin
      send_b('0, 1'b0);
      k++;
    end
    send_b('0, 1'b0);
    check("drain_big", PW'(q_b.size()), '0);
  endtask

  // Directed 4x4 pixel: ch0 = raster index, ch3 carries {-8,-3,-20,-1} in
  // the first window, every other channel 0.
  function automatic logic [PW-1:0] ramp_pix(input int i);
    logic [PW-1:0] p = '0;
    p[0 +: DW] = DW'(i);
    case (i)
      0: p[3*DW +: DW] = -32'sd8;
      1: p[3*DW +: DW] = -32'sd3;
      4: p[3*DW +: DW] = -32'sd20;
      5: p[3*DW +: DW] = -32'sd1;
      default: ;
    endcase
    return p;
  endfunction

  // Extremes: window 0 ch0 all max positive, ch1 all most negative;
  // window 3 ch2 all most negative; everything else random.
  function automatic logic [PW-1:0] extreme_pix(input int i);
    logic [PW-1:0] p = rand_pix();
    if (i == 0 || i == 1 || i == 4 || i == 5) begin
      p[0 +: DW]    = 32'h7FFF_FFFF;
      p[DW +: DW]   = 32'h8000_0000;
    end
    if (i == 10 || i == 11 || i == 14 || i == 15)
      p[2*DW +: DW] = 32'h8000_0000;
    return p;
  endfunction

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (vout_s) begin
        if (q_s.size() == 0) begin
          check("small_unexpected_valid", PW'(vout_s), '0);
        end else begin
          exp_t e;
          e = q_s.pop_front();
          check("small_data", dout_s, e.data);
          check("small_frame_done", PW'(fd_s), PW'(e.fd));
          check("small_latency", PW'(cyc), PW'(e.cyc));
        end
      end else if (fd_s) begin
        check("small_fd_without_valid", PW'(fd_s), '0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (vout_b) begin
        n_vout_b++;
        if (fd_b) n_fd_b++;
        if (q_b.size() == 0) begin
          check("big_unexpected_valid", PW'(vout_b), '0);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          check("big_data", dout_b, e.data);
          check("big_frame_done", PW'(fd_b), PW'(e.fd));
          check("big_latency", PW'(cyc), PW'(e.cyc));
        end
      end else if (fd_b) begin
        check("big_fd_without_valid", PW'(fd_b), '0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int sent;
    rst   = 1'b0;
    din_s = '0;
    vin_s = 1'b0;
    din_b = '0;
    vin_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_out", dout_s, '0);
    check("reset_valid_out", PW'(vout_s), '0);
    check("reset_frame_done", PW'(fd_s), '0);
    check("reset_big_data_out", dout_b, '0);
    rst = 1'b1;

    // Directed ramp frame, continuous valid.
    for (int i = 0; i < SW * SH; i++) send_s(ramp_pix(i), 1'b1);
    drain_s();

    // Same stream with random gaps; invalid cycles carry junk data.
    sent = 0;
    while (sent < SW * SH) begin
      if ($urandom_range(0, 1) == 1) begin
        send_s(ramp_pix(sent), 1'b1);
        sent++;
      end else begin
        send_s(rand_pix(), 1'b0);
      end
    end
    drain_s();

    // Extreme-value windows, back-to-back with two random frames.
    for (int i = 0; i < SW * SH; i++) send_s(extreme_pix(i), 1'b1);
    for (int i = 0; i < 2 * SW * SH; i++) send_s(rand_pix(), 1'b1);
    drain_s();

    // Reset after pixel 9 of a frame, then a fresh frame.
    for (int i = 0; i < 10; i++) send_s(ramp_pix(i), 1'b1);
    @(negedge clk);
    vin_s = 1'b0;
    rst   = 1'b0;
    #1;
    check("midreset_data_out", dout_s, '0);
    check("midreset_valid_out", PW'(vout_s), '0);
    check("midreset_frame_done", PW'(fd_s), '0);
    repeat (2) @(negedge clk);
    check("midreset_hold_data_out", dout_s, '0);
    check("midreset_queue_empty", PW'(q_s.size()), '0);
    q_s.delete();
    pix_s = 0;
    rst   = 1'b1;
    for (int i = 0; i < SW * SH; i++) send_s(ramp_pix(SW * SH - 1 - i), 1'b1);
    drain_s();

    // Two back-to-back random 44x44 frames on the default instance.
    for (int i = 0; i < 2 * BW * BH; i++) send_b(rand_pix(), 1'b1);
    drain_b();
    check("big_valid_count", PW'(n_vout_b), PW'(2 * (BW / 2) * (BH / 2)));
    check("big_frame_done_count", PW'(n_fd_b), PW'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
